// File: rtl/jk_drv_pkg.sv
// Shared types, constants and the per-bit JK excitation rule for jk_excitation_driver.
// Build option: define JK_DRV_MIN_EXCITE_EN for minimal (hold-if-correct) excitation.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;

    // Returns {j, k} that moves a flip-flop currently at c to t; never {1,1}.
    function automatic logic [1:0] excite_bit(input logic t, input logic c);
`ifdef JK_DRV_MIN_EXCITE_EN
        return {t & ~c, ~t & c};
`else
        // c cannot change a forced drive; it is folded in so both builds share one signature
        return {t & (c | ~c), ~t};
`endif
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational WIDTH-bit JK excitation encoder built from the package's per-bit rule.
// Build option: JK_DRV_MIN_EXCITE_EN selects minimal excitation inside jk_drv_pkg.
module jk_excite
    import jk_drv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = excite_bit(target[i], q[i]);
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested state, reads Q back, retries and reports failures.
// Build option: JK_DRV_MIN_EXCITE_EN selects minimal excitation (j/k only on bits that must move).
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [WIDTH-1:0]     tgt_data,
    input  logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 done,
    output logic                 fail,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] MAX_ATT = 3'(MAX_RETRY);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     target, target_nxt;
    logic [2:0]           attempt, attempt_nxt;
    logic [WIDTH-1:0]     j_nxt, k_nxt;
    logic                 done_nxt, fail_nxt;
    logic [ERR_CNT_W-1:0] err_nxt;
    logic [WIDTH-1:0]     exc_src, exc_j, exc_k;

    // One encoder serves both the first drive (fresh tgt_data) and retries (latched target).
    assign exc_src   = (state == ST_IDLE) ? tgt_data : target;
    assign tgt_ready = (state == ST_IDLE);

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .target (exc_src),
        .q      (q),
        .j      (exc_j),
        .k      (exc_k)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt   = state;
        target_nxt  = target;
        attempt_nxt = attempt;
        j_nxt       = '0;
        k_nxt       = '0;
        done_nxt    = 1'b0;
        fail_nxt    = 1'b0;
        err_nxt     = err_count;

        case (state)
            ST_IDLE: begin
                if (tgt_valid) begin
                    state_nxt   = ST_DRIVE;
                    target_nxt  = tgt_data;
                    attempt_nxt = '0;
                    j_nxt       = exc_j;
                    k_nxt       = exc_k;
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (q == target) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (attempt < MAX_ATT) begin
                    state_nxt   = ST_DRIVE;
                    attempt_nxt = attempt + 3'd1;
                    j_nxt       = exc_j;
                    k_nxt       = exc_k;
                end else begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    fail_nxt  = 1'b1;
                    if (err_count != '1) begin
                        err_nxt = err_count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            target    <= '0;
            attempt   <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            target    <= target_nxt;
            attempt   <= attempt_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            done      <= done_nxt;
            fail      <= fail_nxt;
            err_count <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench: behavioural JK bank with stuck-bit injection closes the q loop,
// and a transaction-level model predicts drive values, latency, fail and err_count.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int MR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic         tgt_ready;
    logic [W-1:0] q, j, k;
    logic         done, fail;
    logic [7:0]   err_count;

    logic [W-1:0] bank_q;
    logic [W-1:0] stuck_m = '0;
    logic [W-1:0] stuck_v = '0;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q = '0;
    int exp_err = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q         (q),
        .j         (j),
        .k         (k),
        .done      (done),
        .fail      (fail),
        .err_count (err_count)
    );

    // JK bank: Q+ = J~Q | ~KQ, with stuck bits pinned in the register itself.
    always @(posedge clk) begin
        logic [W-1:0] nxt;
        nxt = rst ? '0 : ((j & ~bank_q) | (~k & bank_q));
        bank_q <= (nxt & ~stuck_m) | (stuck_v & stuck_m);
    end
    assign q = bank_q;

    function automatic logic [W-1:0] ref_j(input logic [W-1:0] t, input logic [W-1:0] c);
`ifdef JK_DRV_MIN_EXCITE_EN
        return t & ~c;
`else
        return t;
`endif
    endfunction

    function automatic logic [W-1:0] ref_k(input logic [W-1:0] t, input logic [W-1:0] c);
`ifdef JK_DRV_MIN_EXCITE_EN
        return ~t & c;
`else
        return ~t;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_stuck(input logic [W-1:0] m, input logic [W-1:0] v);
        stuck_m = m;
        stuck_v = v;
        step;
        exp_q = (exp_q & ~m) | (v & m);
        total++;
        if (q !== exp_q) begin
            bad++;
            $display("FAIL stuck_apply: q=%b want %b", q, exp_q);
        end
    endtask

    // Present a request and wait (bounded) for acceptance; returns at the DRIVE sample.
    task automatic accept(input logic [W-1:0] t);
        int n;
        tgt_valid = 1'b1;
        tgt_data  = t;
        n = 0;
        while (tgt_ready !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        total++;
        if (tgt_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: tgt_ready=%b want 1", tgt_ready);
        end
        step;
        tgt_valid = 1'b0;
        tgt_data  = W'($urandom);
    endtask

    // Walk an accepted request through its predicted DRIVE/CHECK cycles to done.
    task automatic walk(input logic [W-1:0] t);
        logic         pass;
        int           drives;
        logic [W-1:0] ej, ek;
        pass   = (((t ^ stuck_v) & stuck_m) == '0);
        drives = pass ? 1 : MR + 1;
        for (int a = 0; a < drives; a++) begin
            ej = ref_j(t, exp_q);
            ek = ref_k(t, exp_q);
            total++;
            if ({j, k, done, tgt_ready} !== {ej, ek, 2'b00}) begin
                bad++;
                $display("FAIL drive t=%b try=%0d: j=%b k=%b done=%b ready=%b want j=%b k=%b done=0 ready=0",
                         t, a, j, k, done, tgt_ready, ej, ek);
            end
            exp_q = (t & ~stuck_m) | (stuck_v & stuck_m);
            step;
            total++;
            if ({j, k, done, tgt_ready, q} !== {{2*W{1'b0}}, 2'b00, exp_q}) begin
                bad++;
                $display("FAIL check t=%b try=%0d: j=%b k=%b done=%b ready=%b q=%b want 0 0 0 0 q=%b",
                         t, a, j, k, done, tgt_ready, q, exp_q);
            end
            step;
        end
        if (!pass && exp_err < 255) exp_err++;
        total++;
        if ({done, fail, tgt_ready, err_count} !== {1'b1, !pass, 1'b1, 8'(exp_err)}) begin
            bad++;
            $display("FAIL done t=%b: done=%b fail=%b ready=%b err=%0d want 1 %b 1 %0d",
                     t, done, fail, tgt_ready, err_count, !pass, exp_err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total++;
        if ({j, k, done, fail, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_values: j=%b k=%b done=%b fail=%b err=%0d want all 0",
                     j, k, done, fail, err_count);
        end
        rst = 1'b0;
        exp_q = '0;
        exp_err = 0;
        step;
        total++;
        if ({tgt_ready, done, j, k} !== {1'b1, 1'b0, {2*W{1'b0}}}) begin
            bad++;
            $display("FAIL reset_release: ready=%b done=%b j=%b k=%b want 1 0 0 0",
                     tgt_ready, done, j, k);
        end
    endtask

    task automatic test_basic;
        accept(4'b1010);
        walk(4'b1010);
        total++;
        if (q !== 4'b1010) begin
            bad++;
            $display("FAIL basic_q: q=%b want 1010", q);
        end
    endtask

    task automatic test_pattern;
        accept(4'b0110);
        walk(4'b0110);
        total++;
        if (q !== 4'b0110) begin
            bad++;
            $display("FAIL pattern_q: q=%b want 0110", q);
        end
    endtask

    task automatic test_stuck;
        set_stuck(4'b0001, 4'b0000);
        accept(4'b0001);
        walk(4'b0001);
        accept(4'b0000);
        walk(4'b0000);
        set_stuck('0, '0);
    endtask

    task automatic test_back_to_back;
        int n;
        accept(4'b0101);
        total++;
        if ({j, k} !== {ref_j(4'b0101, exp_q), ref_k(4'b0101, exp_q)}) begin
            bad++;
            $display("FAIL b2b_drive: j=%b k=%b", j, k);
        end
        exp_q = 4'b0101;
        step;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        total++;
        if (tgt_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: ready=%b want 0", tgt_ready);
        end
        step;
        total++;
        if ({done, fail, tgt_ready} !== 3'b101) begin
            bad++;
            $display("FAIL b2b_first_done: done=%b fail=%b ready=%b want 1 0 1", done, fail, tgt_ready);
        end
        step;
        tgt_valid = 1'b0;
        tgt_data  = W'($urandom);
        walk(4'b1111);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            step;
            if (done === 1'b1) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL b2b_single_done: extra done pulses=%0d want 0", n);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        accept(4'b1100);
        rst = 1'b1;
        step;
        total++;
        if ({j, k, done, err_count} !== '0) begin
            bad++;
            $display("FAIL midrst: j=%b k=%b done=%b err=%0d want all 0", j, k, done, err_count);
        end
        rst = 1'b0;
        exp_q = '0;
        exp_err = 0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step;
            if (done === 1'b1) n++;
        end
        total++;
        if ({tgt_ready, j, k, q} !== {1'b1, {3*W{1'b0}}} || n != 0) begin
            bad++;
            $display("FAIL midrst_after: ready=%b j=%b k=%b q=%b dones=%0d want 1 0 0 0 0",
                     tgt_ready, j, k, q, n);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] t, m, v;
        for (int r = 0; r < 40; r++) begin
            m = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            v = W'($urandom);
            if (m !== stuck_m || (v & m) !== (stuck_v & stuck_m)) set_stuck(m, v);
            t = W'($urandom);
            accept(t);
            walk(t);
        end
        set_stuck('0, '0);
    endtask

    task automatic test_saturate;
        set_stuck(4'b0001, 4'b0000);
        while (exp_err < 255) begin
            accept(4'b0001);
            walk(4'b0001);
        end
        for (int r = 0; r < 2; r++) begin
            accept(4'b0001);
            walk(4'b0001);
        end
        set_stuck('0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_pattern;
        test_stuck;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
